// File: rtl/result_bcd_encoder.sv
`default_nettype none
// ============================================================================
// Module   : result_bcd_encoder
// Brief    : Sequential double-dabble binary-to-BCD converter with a
//            valid/ready handshake. Optional macro LEADING_ZERO_BLANK_EN
//            blanks leading digits to 4'hF.
// Revision : 1.0
// ============================================================================
module result_bcd_encoder #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      resultIn,
    input  logic [1:0]            divZeroIn,
    input  logic                  inValid,
    output logic                  inReady,
    output logic [4*DIGITS-1:0]   bcdOut,
    output logic [3:0]            digitCount,
    output logic                  errOut,
    output logic                  outValid,
    input  logic                  outReady
);

    localparam int c_CNT_W   = $clog2(WIDTH + 1);
    localparam int c_BCD_W   = 4 * DIGITS;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [c_BCD_W-1:0] c_ERR_BCD = '1;
`else
    localparam logic [c_BCD_W-1:0] c_ERR_BCD = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    logic [WIDTH-1:0]           r_bin;
    logic [c_BCD_W-1:0]         r_bcd;
    logic [c_CNT_W-1:0]         r_bitCnt;

    logic [c_BCD_W-1:0]         w_adj;
    logic [c_BCD_W+WIDTH-1:0]   w_step;
    logic [c_BCD_W-1:0]         w_nextBcd;
    logic [WIDTH-1:0]           w_nextBin;
    logic [c_BCD_W-1:0]         w_finalBcd;
    logic [3:0]                 w_digitCount;

    // Per-digit add-3 correction, 4 bits wide with no inter-digit carry.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                  (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
    end

    assign w_step    = {w_adj, r_bin} << 1;
    assign w_nextBcd = w_step[c_BCD_W+WIDTH-1:WIDTH];
    assign w_nextBin = w_step[WIDTH-1:0];

    always_comb begin
        w_digitCount = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_nextBcd[4*i +: 4] != 4'd0) begin
                w_digitCount = 4'(i + 1);
            end
        end
    end

    always_comb begin
        w_finalBcd = w_nextBcd;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(w_digitCount)) begin
                w_finalBcd[4*i +: 4] = 4'hF;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_bitCnt   <= '0;
            inReady    <= 1'b1;
            outValid   <= 1'b0;
            bcdOut     <= '0;
            digitCount <= 4'd0;
            errOut     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (inValid && inReady) begin
                        inReady <= 1'b0;
                        if (divZeroIn != 2'b00) begin
                            r_state    <= S_DONE;
                            outValid   <= 1'b1;
                            errOut     <= 1'b1;
                            bcdOut     <= c_ERR_BCD;
                            digitCount <= 4'd1;
                        end else begin
                            r_state  <= S_CONV;
                            r_bin    <= resultIn;
                            r_bcd    <= '0;
                            r_bitCnt <= c_CNT_W'(WIDTH);
                        end
                    end
                end
                S_CONV: begin
                    r_bcd    <= w_nextBcd;
                    r_bin    <= w_nextBin;
                    r_bitCnt <= r_bitCnt - c_CNT_W'(1);
                    if (r_bitCnt == c_CNT_W'(1)) begin
                        r_state    <= S_DONE;
                        outValid   <= 1'b1;
                        errOut     <= 1'b0;
                        bcdOut     <= w_finalBcd;
                        digitCount <= w_digitCount;
                    end
                end
                S_DONE: begin
                    // Ready is raised only after the consume edge, so no same-edge reload.
                    if (outReady) begin
                        r_state  <= S_IDLE;
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    inReady <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_bcd_encoder.sv
`default_nettype none
// Testbench for result_bcd_encoder: directed and random operands checked
// against a decimal reference model.
module tb_result_bcd_encoder;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [WIDTH-1:0]     resultIn = '0;
    logic [1:0]           divZeroIn = '0;
    logic                 inValid = 1'b0;
    logic                 inReady;
    logic [4*DIGITS-1:0]  bcdOut;
    logic [3:0]           digitCount;
    logic                 errOut;
    logic                 outValid;
    logic                 outReady = 1'b0;

    int nTests = 0;
    int nFail  = 0;

    result_bcd_encoder #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .resultIn   (resultIn),
        .divZeroIn  (divZeroIn),
        .inValid    (inValid),
        .inReady    (inReady),
        .bcdOut     (bcdOut),
        .digitCount (digitCount),
        .errOut     (errOut),
        .outValid   (outValid),
        .outReady   (outReady)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal digits by repeated division, then optional leading blanking.
    function automatic void model(input logic [WIDTH-1:0] v, input logic [1:0] dz,
                                  output logic [4*DIGITS-1:0] bcd, output logic [3:0] cnt);
        longint unsigned x;
        longint unsigned d;
        x   = 64'(v);
        bcd = '0;
        cnt = 4'd1;
        if (dz != 2'b00) begin
`ifdef LEADING_ZERO_BLANK_EN
            bcd = '1;
`endif
            return;
        end
        for (int i = 0; i < DIGITS; i++) begin
            d = x % 10;
            bcd[4*i +: 4] = 4'(d);
            x = x / 10;
            if (d != 0) cnt = 4'(i + 1);
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(cnt)) bcd[4*i +: 4] = 4'hF;
        end
`endif
    endfunction

    task automatic checkReset();
        check("rst_inReady",    64'(inReady),    64'(1));
        check("rst_outValid",   64'(outValid),   64'(0));
        check("rst_bcdOut",     64'(bcdOut),     64'(0));
        check("rst_digitCount", 64'(digitCount), 64'(0));
        check("rst_errOut",     64'(errOut),     64'(0));
    endtask

    task automatic runOp(input logic [WIDTH-1:0] v, input logic [1:0] dz, input int hold);
        int waitCnt;
        int lat;
        logic [4*DIGITS-1:0] expBcd;
        logic [3:0]          expCnt;
        waitCnt = 0;
        while (!inReady && waitCnt < 100) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        check("inReady_idle", 64'(inReady), 64'(1));
        resultIn  = v;
        divZeroIn = dz;
        inValid   = 1'b1;
        @(posedge clk); #1;
        check("inReady_busy", 64'(inReady), 64'(0));
        // Garbage on the input side while busy must be ignored.
        resultIn  = $urandom;
        divZeroIn = 2'($urandom_range(0, 3));
        lat = 0;
        while (!outValid && lat < WIDTH + 5) begin
            @(posedge clk); #1;
            lat++;
        end
        inValid = 1'b0;
        check("latency", 64'(lat), (dz != 2'b00) ? 64'(0) : 64'(WIDTH));
        model(v, dz, expBcd, expCnt);
        check("bcdOut",     64'(bcdOut),     64'(expBcd));
        check("digitCount", 64'(digitCount), 64'(expCnt));
        check("errOut",     64'(errOut),     (dz != 2'b00) ? 64'(1) : 64'(0));
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            check("hold_outValid", 64'(outValid), 64'(1));
            check("hold_inReady",  64'(inReady),  64'(0));
            check("hold_bcdOut",   64'(bcdOut),   64'(expBcd));
            check("hold_count",    64'(digitCount), 64'(expCnt));
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        check("consume_outValid", 64'(outValid), 64'(0));
        check("consume_inReady",  64'(inReady),  64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] v;
        logic [1:0]       dz;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkReset();
        rst_n = 1'b1;

        runOp(32'd1234, 2'b00, 5);
        runOp(32'd99, 2'b00, 0);
        runOp(32'hFFFF_FFFF, 2'b00, 0);
        runOp(32'd0, 2'b00, 1);
        runOp(32'd7, 2'b01, 3);
        runOp(32'd1_000_000_000, 2'b00, 0);

        // Abort a conversion midway with reset.
        resultIn  = 32'd5555;
        divZeroIn = 2'b00;
        inValid   = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkReset();
        runOp(32'd42, 2'b00, 0);

        for (int k = 0; k < 25; k++) begin
            v  = $urandom >> $urandom_range(0, 31);
            dz = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            runOp(v, dz, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
